// File: rtl/answer_window_navigator_pkg.sv
// Shared types and timing defaults for the answer-window navigator.
// Autorepeat support is selected by the ANSWER_NAV_AUTOREPEAT_EN macro in the top module.
package answer_nav_pkg;

  typedef enum logic [1:0] {
    NAV_IDLE,
    NAV_DELAY,
    NAV_REPEAT
  } nav_state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } nav_dir_e;

  localparam int DEF_REPEAT_DELAY  = 25_000_000;
  localparam int DEF_REPEAT_PERIOD = 10_000_000;

  // A single-position display still needs a one-bit code.
  function automatic int code_width(input int max_code);
    return (max_code < 1) ? 1 : $clog2(max_code + 1);
  endfunction

endpackage

// File: rtl/answer_window_navigator_if.sv
// Button inputs and window outputs of the answer-window navigator.
// The master drives the buttons; the slave (navigator) drives the window state.
interface answer_window_navigator_if
  import answer_nav_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int WIN_W    = 4
);
  localparam int CODE_W = code_width(NUM_LEDS - WIN_W);

  logic                in_step_up;
  logic                in_step_down;
  logic                in_home;
  logic [CODE_W-1:0]   out_answer_select_code;
  logic [NUM_LEDS-1:0] out_LED;
  logic                out_at_min;
  logic                out_at_max;
  logic                out_moved;

  modport master (
    output in_step_up, in_step_down, in_home,
    input  out_answer_select_code, out_LED, out_at_min, out_at_max, out_moved
  );

  modport slave (
    input  in_step_up, in_step_down, in_home,
    output out_answer_select_code, out_LED, out_at_min, out_at_max, out_moved
  );
endinterface

// File: rtl/answer_window_navigator_decoder.sv
// Maps a window code to an LED mask with WIN_W contiguous bits starting at the code.
// Purely combinational; reusable by any display path that shows a sliding window.
module answer_window_decoder
  import answer_nav_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int WIN_W    = 4,
  localparam int CODE_W  = code_width(NUM_LEDS - WIN_W)
) (
  input  logic [CODE_W-1:0]   code_i,
  output logic [NUM_LEDS-1:0] led_o
);
  always_comb begin
    led_o = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_o[i] = (i >= int'(code_i)) && (i < int'(code_i) + WIN_W);
    end
  end
endmodule

// File: rtl/answer_window_navigator.sv
// Steps the answer-window code from up/down/home buttons, saturating or wrapping.
// Define ANSWER_NAV_AUTOREPEAT_EN to compile in hold-to-auto-repeat (DELAY/REPEAT states).
module answer_window_navigator
  import answer_nav_pkg::*;
#(
  parameter int NUM_LEDS      = 8,
  parameter int WIN_W         = 4,
  parameter int WRAP          = 0,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic                      clk,
  input logic                      rst_n,
  answer_window_navigator_if.slave nav
);
  localparam int MAX_CODE = NUM_LEDS - WIN_W;
  localparam int CODE_W   = code_width(MAX_CODE);
  localparam logic [CODE_W-1:0] MAX_C = CODE_W'(MAX_CODE);

  if (NUM_LEDS < 2 || WIN_W < 1 || WIN_W > NUM_LEDS || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2)
  begin : g_bad_cfg
    $error("answer_window_navigator: illegal parameter set");
  end

  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   code_d;
  logic [NUM_LEDS-1:0] led;
  logic                moved_q;
  logic                up_prev_q;
  logic                down_prev_q;
  logic                dir_rise;
  nav_dir_e            cur_dir;

  always_comb begin
    cur_dir = DIR_NONE;
    if (nav.in_step_up && !nav.in_step_down)      cur_dir = DIR_UP;
    else if (nav.in_step_down && !nav.in_step_up) cur_dir = DIR_DOWN;
  end

  // A press only counts if neither button was held on the previous sample.
  assign dir_rise = (cur_dir != DIR_NONE) && !up_prev_q && !down_prev_q;

  always_comb begin
    code_d = code_q;
    case (cur_dir)
      DIR_UP:   code_d = (code_q < MAX_C) ? code_q + 1'b1 : ((WRAP != 0) ? '0 : MAX_C);
      DIR_DOWN: code_d = (code_q != '0) ? code_q - 1'b1 : ((WRAP != 0) ? MAX_C : '0);
      default:  code_d = code_q;
    endcase
  end

`ifdef ANSWER_NAV_AUTOREPEAT_EN
  localparam int CNT_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

  nav_state_e       state_q;
  nav_dir_e         dir_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q      <= '0;
      moved_q     <= 1'b0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      state_q     <= NAV_IDLE;
      dir_q       <= DIR_NONE;
      cnt_q       <= '0;
    end else begin
      up_prev_q   <= nav.in_step_up;
      down_prev_q <= nav.in_step_down;
      moved_q     <= 1'b0;
      if (nav.in_home) begin
        code_q  <= '0;
        moved_q <= (code_q != '0);
        state_q <= NAV_IDLE;
        dir_q   <= DIR_NONE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          NAV_IDLE: begin
            if (dir_rise) begin
              code_q  <= code_d;
              moved_q <= (code_d != code_q);
              dir_q   <= cur_dir;
              cnt_q   <= DELAY_LD;
              state_q <= NAV_DELAY;
            end
          end
          NAV_DELAY, NAV_REPEAT: begin
            // Release, reversal or both-held all show up as a direction change.
            if (cur_dir != dir_q) begin
              state_q <= NAV_IDLE;
              dir_q   <= DIR_NONE;
              cnt_q   <= '0;
            end else if (cnt_q == '0) begin
              code_q  <= code_d;
              moved_q <= (code_d != code_q);
              cnt_q   <= PERIOD_LD;
              state_q <= NAV_REPEAT;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= NAV_IDLE;
            dir_q   <= DIR_NONE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q      <= '0;
      moved_q     <= 1'b0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
    end else begin
      up_prev_q   <= nav.in_step_up;
      down_prev_q <= nav.in_step_down;
      moved_q     <= 1'b0;
      if (nav.in_home) begin
        code_q  <= '0;
        moved_q <= (code_q != '0);
      end else if (dir_rise) begin
        code_q  <= code_d;
        moved_q <= (code_d != code_q);
      end
    end
  end
`endif

  answer_window_decoder #(
    .NUM_LEDS (NUM_LEDS),
    .WIN_W    (WIN_W)
  ) u_decoder (
    .code_i (code_q),
    .led_o  (led)
  );

  assign nav.out_answer_select_code = code_q;
  assign nav.out_LED                = led;
  assign nav.out_at_min             = (code_q == '0);
  assign nav.out_at_max             = (code_q == MAX_C);
  assign nav.out_moved              = moved_q;
endmodule

// File: tb/tb_answer_window_navigator.sv
// Directed bench for answer_window_navigator: a saturating and a wrapping instance share stimulus.
// Expectations are queued per step and checked against both instances after each clock edge.
module tb_answer_window_navigator;
  import answer_nav_pkg::*;

`ifdef ANSWER_NAV_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int RD = 5;
  localparam int RP = 3;

  typedef struct {
    string tag;
    int    cs;
    int    cw;
    bit    ms;
    bit    mw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  answer_window_navigator_if #(.NUM_LEDS(8), .WIN_W(4)) if_sat ();
  answer_window_navigator_if #(.NUM_LEDS(8), .WIN_W(4)) if_wrap ();

  answer_window_navigator #(.NUM_LEDS(8), .WIN_W(4), .WRAP(0),
                            .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_sat (
    .clk (clk), .rst_n (rst_n), .nav (if_sat.slave)
  );
  answer_window_navigator #(.NUM_LEDS(8), .WIN_W(4), .WRAP(1),
                            .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_wrap (
    .clk (clk), .rst_n (rst_n), .nav (if_wrap.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_pop();
    exp_t e;
    logic [7:0] ls, lw;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e  = sb.pop_front();
    ls = 8'h0F << e.cs;
    lw = 8'h0F << e.cw;
    chk({e.tag, ":sat_code"},  32'(if_sat.out_answer_select_code),  32'(e.cs));
    chk({e.tag, ":sat_led"},   32'(if_sat.out_LED),                 32'(ls));
    chk({e.tag, ":sat_min"},   32'(if_sat.out_at_min),              32'(e.cs == 0));
    chk({e.tag, ":sat_max"},   32'(if_sat.out_at_max),              32'(e.cs == 4));
    chk({e.tag, ":sat_moved"}, 32'(if_sat.out_moved),               32'(e.ms));
    chk({e.tag, ":wrp_code"},  32'(if_wrap.out_answer_select_code), 32'(e.cw));
    chk({e.tag, ":wrp_led"},   32'(if_wrap.out_LED),                32'(lw));
    chk({e.tag, ":wrp_min"},   32'(if_wrap.out_at_min),             32'(e.cw == 0));
    chk({e.tag, ":wrp_max"},   32'(if_wrap.out_at_max),             32'(e.cw == 4));
    chk({e.tag, ":wrp_moved"}, 32'(if_wrap.out_moved),              32'(e.mw));
  endtask

  task automatic drive(input logic up, input logic dn, input logic home);
    if_sat.in_step_up    = up;
    if_sat.in_step_down  = dn;
    if_sat.in_home       = home;
    if_wrap.in_step_up   = up;
    if_wrap.in_step_down = dn;
    if_wrap.in_home      = home;
  endtask

  task automatic cyc(input logic up, input logic dn, input logic home,
                     input int cs, input int cw, input bit ms, input bit mw, input string tag);
    exp_t e;
    @(negedge clk);
    drive(up, dn, home);
    e.tag = tag; e.cs = cs; e.cw = cw; e.ms = ms; e.mw = mw;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    #20000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int n;
    drive(1'b0, 1'b0, 1'b0);
    #3;
    e.tag = "reset"; e.cs = 0; e.cw = 0; e.ms = 0; e.mw = 0;
    sb.push_back(e);
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, "idle");

    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, 0, i, i, 1, 1, $sformatf("up%0d", i));
      cyc(0, 0, 0, i, i, 0, 0, $sformatf("up%0d_rel", i));
    end
    cyc(1, 0, 0, 4, 0, 0, 1, "up5_end");
    cyc(0, 0, 0, 4, 0, 0, 0, "up5_rel");
    cyc(0, 1, 0, 3, 4, 1, 1, "down_end");
    cyc(0, 0, 0, 3, 4, 0, 0, "down_rel");

    cyc(1, 1, 0, 3, 4, 0, 0, "both_a");
    cyc(1, 1, 0, 3, 4, 0, 0, "both_b");
    cyc(0, 0, 0, 3, 4, 0, 0, "both_rel");
    cyc(1, 0, 0, 4, 0, 1, 1, "hold_up");
    cyc(1, 1, 0, 4, 0, 0, 0, "down_while_up");
    cyc(1, 0, 0, 4, 0, 0, 0, "down_released");
    cyc(0, 0, 0, 4, 0, 0, 0, "all_rel");
    cyc(0, 0, 1, 0, 0, 1, 0, "home");
    cyc(0, 0, 0, 0, 0, 0, 0, "home_rel");

    for (int i = 0; i < 12; i++) begin
      n = AR ? (1 + ((i >= RD) ? 1 + (i - RD) / RP : 0)) : 1;
      cyc(1, 0, 0, n, n,
          AR ? (i == 0 || (i >= RD && (i - RD) % RP == 0)) : (i == 0),
          AR ? (i == 0 || (i >= RD && (i - RD) % RP == 0)) : (i == 0),
          $sformatf("rep%0d", i));
    end
    n = AR ? 4 : 1;
    cyc(0, 0, 0, n, n, 0, 0, "rep_rel");

    cyc(0, 0, 1, 0, 0, 1, 1, "home2");
    cyc(0, 0, 0, 0, 0, 0, 0, "home2_rel");
    for (int i = 1; i <= 2; i++) begin
      cyc(1, 0, 0, i, i, 1, 1, $sformatf("to2_%0d", i));
      cyc(0, 0, 0, i, i, 0, 0, $sformatf("to2_%0d_rel", i));
    end
    cyc(1, 0, 0, 3, 3, 1, 1, "to3_held");
    cyc(1, 0, 1, 0, 0, 1, 1, "home_held_up");
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 0, 0, $sformatf("after_home%0d", i));
    cyc(0, 0, 0, 0, 0, 0, 0, "after_home_rel");
    cyc(1, 0, 0, 1, 1, 1, 1, "repress");
    cyc(0, 0, 0, 1, 1, 0, 0, "repress_rel");

    cyc(1, 0, 0, 2, 2, 1, 1, "delay_enter");
    cyc(1, 0, 0, 2, 2, 0, 0, "delay_a");
    cyc(1, 0, 0, 2, 2, 0, 0, "delay_b");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    e.tag = "async_reset"; e.cs = 0; e.cw = 0; e.ms = 0; e.mw = 0;
    sb.push_back(e);
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, "post_reset");
    cyc(1, 0, 0, 1, 1, 1, 1, "post_press");
    for (int i = 1; i < RD - 1; i++) cyc(1, 0, 0, 1, 1, 0, 0, $sformatf("post_hold%0d", i));
    cyc(0, 0, 0, 1, 1, 0, 0, "post_rel");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
